// File: rtl/hex_display_driver.sv
// hex_display_driver
//   Takes the 32-bit word from the display debugger mux and drives eight
//   active-low seven-segment digits. It holds a snapshot of the word, can be
//   frozen with a debounced pushbutton, can capture only when the processor
//   stage changes, blanks leading zeros, and blinks every digit that changed
//   at the last snapshot update.
//
// Ports
//   Clock            : system clock, rising edge
//   Reset            : asynchronous, active-high
//   HexDisplay32Bits : word from the display mux, nibble i -> HEXi
//   Stage            : processor stage counter (0..4)
//   Capture_On_Stage : 1 = capture only when Stage changes, 0 = every cycle
//   Freeze_n         : raw active-low pushbutton, asynchronous to Clock
//   HEX0..HEX7       : registered segment drives {g,f,e,d,c,b,a}, active-low
//   Frozen           : 1 while the snapshot is held
//   Changed_Mask     : bit i = 1 when nibble i of Shown differs from Prev
//
// Handshake: none. Every input is sampled on each rising Clock edge; there is
// no valid/ready pairing on this block.
module hex_display_driver #(
  parameter int BLINK_DIV       = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BLANK_LEADING   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] HexDisplay32Bits,
  input  logic [2:0]  Stage,
  input  logic        Capture_On_Stage,
  input  logic        Freeze_n,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        Frozen,
  output logic [7:0]  Changed_Mask
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;
  localparam logic [6:0]    UPPER_RST  = BLANK_LEADING ? 7'h7F : 7'h40;
  localparam logic [7:0][6:0] HEX_RST  = {{7{UPPER_RST}}, 7'h40};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            frozen_q, frozen_d;
  logic [2:0]      stage_prev_q, stage_prev_d;
  logic [31:0]     shown_q, shown_d;
  logic [31:0]     prev_q, prev_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [7:0][6:0] hex_q, hex_d;

  logic            press;
  logic            capture;
  logic [7:0]      changed;
  logic [7:0]      upper_zero;

  // Freeze button: synchronise, then accept a new level only after
  // DEBOUNCE_CYCLES consecutive samples that disagree with the current one.
  always_comb begin
    sync1_d   = Freeze_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    // Only the press (debounced 1->0) toggles the freeze state.
    press    = deb_q & ~deb_d;
    frozen_d = frozen_q ^ press;
  end

  // Snapshot capture. Uses the current Frozen, so a press landing on a
  // capture cycle lets that capture complete before the hold begins.
  always_comb begin
    stage_prev_d = Stage;
    shown_d      = shown_q;
    prev_d       = prev_q;
    capture      = ~frozen_q & (~Capture_On_Stage | (Stage != stage_prev_q));
    if (capture && (HexDisplay32Bits != shown_q)) begin
      prev_d  = shown_q;
      shown_d = HexDisplay32Bits;
    end
  end

  // Changed_Mask is derived from the Shown/Prev pair: both are only ever
  // updated together, so this matches the nibble difference at capture.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      changed[i] = (shown_q[4*i +: 4] != prev_q[4*i +: 4]);
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // upper_zero[i] is set when nibbles i..7 are all zero; digit 0 is never
  // blanked by the leading-zero rule so a zero word still shows "0".
  always_comb begin
    upper_zero[7] = (shown_q[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] & (shown_q[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < 8; i++) begin
      if ((BLANK_LEADING && (i != 0) && upper_zero[i]) || (phase_q && changed[i])) begin
        hex_d[i] = SEG_BLANK;
      end else begin
        hex_d[i] = seg7(shown_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      deb_q        <= 1'b1;
      deb_cnt_q    <= '0;
      frozen_q     <= 1'b0;
      stage_prev_q <= 3'd0;
      shown_q      <= '0;
      prev_q       <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      hex_q        <= HEX_RST;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      frozen_q     <= frozen_d;
      stage_prev_q <= stage_prev_d;
      shown_q      <= shown_d;
      prev_q       <= prev_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      hex_q        <= hex_d;
    end
  end

  assign HEX0         = hex_q[0];
  assign HEX1         = hex_q[1];
  assign HEX2         = hex_q[2];
  assign HEX3         = hex_q[3];
  assign HEX4         = hex_q[4];
  assign HEX5         = hex_q[5];
  assign HEX6         = hex_q[6];
  assign HEX7         = hex_q[7];
  assign Frozen       = frozen_q;
  assign Changed_Mask = changed;

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

  localparam int BLINK_DIV = 4;
  localparam int DEB       = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] word = '0;
  logic [2:0]  stage = '0;
  logic        cos = 1'b0;
  logic        freeze_n = 1'b1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        frozen;
  logic [7:0]  mask;
  logic [55:0] dut_hex;

  always #5 clk = ~clk;
  assign dut_hex = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  hex_display_driver #(
    .BLINK_DIV(BLINK_DIV), .DEBOUNCE_CYCLES(DEB), .BLANK_LEADING(1'b1)
  ) dut (
    .Clock(clk), .Reset(rst), .HexDisplay32Bits(word), .Stage(stage),
    .Capture_On_Stage(cos), .Freeze_n(freeze_n),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .HEX4(hex4), .HEX5(hex5), .HEX6(hex6), .HEX7(hex7),
    .Frozen(frozen), .Changed_Mask(mask)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_shown;
  logic [7:0]  m_mask;
  logic        m_frozen;
  logic [2:0]  m_stage_d;
  logic        m_s1, m_s2, m_level;
  int          m_run;
  int          m_ticks;
  logic [55:0] m_hex;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [55:0] ref_disp(input logic [31:0] w, input logic [7:0] mk, input int ph);
    logic [55:0] r;
    logic [31:0] upper;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      upper = w >> (4 * i);
      if ((i > 0 && upper == 0) || (ph == 1 && mk[i])) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = seg_ref(w[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic int state_phase();
    return (m_ticks / BLINK_DIV) % 2;
  endfunction

  // Phase that governed the value currently on the registered outputs.
  function automatic int disp_phase();
    return (m_ticks == 0) ? 0 : ((m_ticks - 1) / BLINK_DIV) % 2;
  endfunction

  task automatic model_reset();
    m_shown = '0; m_mask = '0; m_frozen = 1'b0; m_stage_d = '0;
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_run = 0; m_ticks = 0;
    m_hex = ref_disp(32'h0, 8'h0, 0);
  endtask

  task automatic model_step();
    logic [55:0] new_hex;
    logic        press;
    logic        cap;
    new_hex = ref_disp(m_shown, m_mask, state_phase());
    press = 1'b0;
    if (m_s2 != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = m_s2;
        m_run   = 0;
        press   = (m_level == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = freeze_n;
    cap = !m_frozen && (!cos || stage != m_stage_d);
    if (cap && word != m_shown) begin
      for (int i = 0; i < 8; i++) m_mask[i] = (word[4*i +: 4] != m_shown[4*i +: 4]);
      m_shown = word;
    end
    if (press) m_frozen = !m_frozen;
    m_stage_d = stage;
    m_ticks++;
    m_hex = new_hex;
  endtask

  task automatic check_model();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("model_hex%0d", i), 64'(dut_hex[7*i +: 7]), 64'(m_hex[7*i +: 7]));
    end
    check("model_frozen", 64'(frozen), 64'(m_frozen));
    check("model_mask", 64'(mask), 64'(m_mask));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at negedge; model steps with the DUT edge; checks at negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic hold_freeze(input int n);
    freeze_n = 1'b0;
    repeat (n) tick();
    freeze_n = 1'b1;
  endtask

  task automatic check_deadbeef(input string name);
    check({name, "_mask"}, 64'(mask), 64'hFF);
    if (disp_phase() == 0)
      check({name, "_hex"}, 64'(dut_hex),
            64'({7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));
    else
      check({name, "_hex_blink"}, 64'(dut_hex), 64'({8{7'h7F}}));
  endtask

  task automatic check_1234(input string name);
    check({name, "_mask"}, 64'(mask), 64'hFF);
    if (disp_phase() == 0)
      check({name, "_hex"}, 64'(dut_hex),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
    else
      check({name, "_hex_blink"}, 64'(dut_hex), 64'({8{7'h7F}}));
  endtask

  typedef struct {
    logic [31:0] word;
    logic [55:0] hex;
    logic [7:0]  mask;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n79, n7f, hold_left, lim;

    vecs[0] = '{32'h0000_00A5, {{6{7'h7F}}, 7'h08, 7'h12}, 8'h03};
    vecs[1] = '{32'h0000_0000, {{7{7'h7F}}, 7'h40}, 8'h00};
    vecs[2] = '{32'h1234_5678, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hFF};
    vecs[3] = '{32'h9ABC_DEF0, {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}, 8'hFE};
    vecs[4] = '{32'h0010_0000, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h20};
    vecs[5] = '{32'h0000_000F, {{7{7'h7F}}, 7'h0E}, 8'h01};

    @(negedge clk);
    do_reset();
    check("reset_hex", 64'(dut_hex), 64'({{7{7'h7F}}, 7'h40}));
    check("reset_frozen", 64'(frozen), 64'(0));
    check("reset_mask", 64'(mask), 64'h00);

    // Decode and leading-zero blanking from a fresh reset, two edges later.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      word = vecs[v].word;
      tick();
      tick();
      check($sformatf("vec%0d_hex", v), 64'(dut_hex), 64'(vecs[v].hex));
      check($sformatf("vec%0d_mask", v), 64'(mask), 64'(vecs[v].mask));
    end

    // Blink of the changed digit.
    do_reset();
    word = 32'h0000_00A5;
    tick(); tick();
    word = 32'h0000_01A5;
    tick(); tick();
    check("blink_mask", 64'(mask), 64'h04);
    n79 = 0; n7f = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("blink_hex0", 64'(hex0), 64'h12);
      check("blink_hex1", 64'(hex1), 64'h08);
      if (hex2 == 7'h79) n79++;
      if (hex2 == 7'h7F) n7f++;
    end
    check("blink_hex2_on", 64'(n79), 64'(8));
    check("blink_hex2_off", 64'(n7f), 64'(8));

    // Freeze: short bounce rejected, long press accepted.
    hold_freeze(2);
    repeat (6) tick();
    check("bounce_frozen", 64'(frozen), 64'(0));
    hold_freeze(6);
    repeat (6) tick();
    check("press_frozen", 64'(frozen), 64'(1));
    word = 32'hDEAD_BEEF;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("frozen_hex_steady", 64'({hex7, hex6, hex5, hex4, hex3, hex1, hex0}),
            64'({{5{7'h7F}}, 7'h08, 7'h12}));
      check("frozen_mask", 64'(mask), 64'h04);
    end
    hold_freeze(6);
    repeat (6) tick();
    check("unfreeze_frozen", 64'(frozen), 64'(0));
    for (int c = 0; c < 8; c++) begin
      tick();
      check_deadbeef("unfreeze");
    end

    // Capture only on stage change.
    cos = 1'b1; stage = 3'd2;
    tick(); tick();
    for (int c = 0; c < 6; c++) begin
      word = $urandom & 32'hFFFF_FFF0;
      tick();
      check_deadbeef("stage_hold");
    end
    stage = 3'd3; word = 32'h0000_1234;
    tick();
    word = 32'h5555_5555;
    tick();
    check_1234("stage_step");
    tick(); tick();
    check_1234("stage_after");

    // Reset while frozen with the blink phase high.
    cos = 1'b0; word = 32'h0000_1234;
    hold_freeze(6);
    repeat (6) tick();
    check("pre_reset_frozen", 64'(frozen), 64'(1));
    lim = 0;
    while (state_phase() == 0 && lim < 8) begin
      tick();
      lim++;
    end
    check("pre_reset_phase", 64'(state_phase()), 64'(1));
    rst = 1'b1;
    model_reset();
    #1;
    check("midreset_frozen", 64'(frozen), 64'(0));
    check("midreset_mask", 64'(mask), 64'h00);
    check("midreset_hex", 64'(dut_hex), 64'({{7{7'h7F}}, 7'h40}));
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Randomised run against the model, with one reset in the middle.
    hold_left = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      if ($urandom_range(0, 3) != 0) word = $urandom & {8{$urandom_range(0, 1) ? 4'hF : 4'h3}};
      stage = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) cos = ~cos;
      if (hold_left == 0) begin
        freeze_n  = ~freeze_n;
        hold_left = $urandom_range(1, 8);
      end
      hold_left--;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Sits directly downstream of the display debugger mux. Consumes its 32-bit HexDisplay32Bits word and drives the eight active-low seven-segment digits HEX7..HEX0.
- Adds a snapshot register, a debounced freeze pushbutton, optional capture only on processor stage changes, leading-zero blanking, and blinking of any digit that changed since the previous snapshot.

Parameters:
- BLINK_DIV, 25000000: Clock cycles per blink half-period (0.5 s at 50 MHz). Minimum 2.
- DEBOUNCE_CYCLES, 500000: Consecutive stable synchronised samples required to accept a new Freeze_n level. Minimum 1.
- BLANK_LEADING, 1: 1 = blank leading-zero digits; 0 = show all eight digits.

Ports:
- Clock  input  1  System clock; all state updates on the rising edge.
- Reset  input  1  Asynchronous, active-high reset.
- HexDisplay32Bits  input  32  Word from the display mux; nibble i drives digit HEXi.
- Stage  input  3  Processor stage counter (0..4).
- Capture_On_Stage  input  1  1 = capture only when Stage changes; 0 = capture every cycle.
- Freeze_n  input  1  Raw active-low pushbutton, asynchronous to Clock.
- HEX0..HEX7  output  7 each  Segment drives {g,f,e,d,c,b,a}, active-low.
- Frozen  output  1  1 while the snapshot is held.
- Changed_Mask  output  8  Bit i = 1 when nibble i of Shown differs from Prev.

Behaviour:
- Reset values: Shown = 0, Prev = 0, Stage_d = 0, Frozen = 0, Changed_Mask = 0.
  - Blink counter = 0, blink phase = 0.
  - Sync flops = 1, debounced level = 1, debounce counter = 0.
  - HEX0 = 7'h40. HEX7..HEX1 = 7'h7F when BLANK_LEADING = 1, else 7'h40.
- Reset asserted mid-operation clears all of the above immediately, including any partial debounce count.
- Capture event, cycle n:
  - Only when Frozen = 0.
  - Capture_On_Stage = 0: every cycle.
  - Capture_On_Stage = 1: only when Stage != Stage_d. Stage_d registers Stage every cycle, including while Frozen.
- On a capture event where HexDisplay32Bits != Shown:
  - Prev <= Shown, Shown <= HexDisplay32Bits.
  - Changed_Mask[i] <= (HexDisplay32Bits nibble i != Shown nibble i).
- On a capture event with an equal value, Shown, Prev and Changed_Mask all hold.
- Latency (Capture_On_Stage = 0): input at edge n -> Shown at n+1 -> HEX outputs at n+2. HEX outputs are registered.
- Freeze_n handling:
  - Two-flop synchroniser.
  - Debounce counter resets to 0 whenever the synchronised value equals the debounced level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synchronised value and the counter clears.
  - A 1->0 transition of the debounced level (press) toggles Frozen. Release has no effect.
- While Frozen = 1: Shown, Prev and Changed_Mask hold. The blink counter keeps running.
- Blink:
  - Counter counts 0..BLINK_DIV-1, then wraps to 0.
  - Phase toggles on the cycle the counter wraps.
  - Digit i is forced to 7'h7F when phase = 1 and Changed_Mask[i] = 1.
- Leading-zero blanking (BLANK_LEADING = 1):
  - Let k = index of the highest nonzero nibble of Shown.
  - Digits above k are forced to 7'h7F.
  - HEX0 is never blank-forced by this rule; Shown = 0 shows a single "0".
  - Blink blanking and leading-zero blanking are ORed.
- Segment codes, nibble 0..F:
  - 0..7: 40, 79, 24, 30, 19, 12, 02, 78.
  - 8..F: 00, 10, 08, 03, 46, 21, 06, 0E.
- Simultaneous events:
  - A debounced press in the same cycle as a capture event: the capture completes, and Frozen = 1 from the next cycle.
  - Blink wrap with a mask change: the new mask is used together with the new phase.

Test Plan:
- Bench parameters throughout: BLINK_DIV = 4, DEBOUNCE_CYCLES = 3.
- Leading-zero blanking:
  - Apply Reset, then release; hold HexDisplay32Bits = 32'h0000_00A5 with Capture_On_Stage = 0.
  - Required two edges later: HEX0 = 7'h12, HEX1 = 7'h08, HEX2..HEX7 = 7'h7F.
  - Changed_Mask = 8'h03.
- Blink of changed digits:
  - Step the input 32'h0000_00A5 -> 32'h0000_01A5.
  - Required: Changed_Mask = 8'h04.
  - HEX2 alternates between 7'h79 and 7'h7F every 4 cycles; HEX1 and HEX0 stay steady.
- Freeze:
  - Pulse Freeze_n low for 2 cycles.
  - Required: Frozen stays 0 (bounce rejected).
  - Hold Freeze_n low for 6 cycles, then change the input to 32'hDEAD_BEEF.
  - Required: Frozen = 1, and HEX0..HEX7 are unchanged.
  - Press again: Frozen = 0, and HEX7..HEX0 show D,E,A,D,B,E,E,F with Changed_Mask = 8'hFF.
- Capture on stage change:
  - Set Capture_On_Stage = 1, hold Stage = 2, and change the input each cycle.
  - Required: Shown is constant.
  - Step Stage 2 -> 3 while the input = 32'h0000_1234.
  - Required: Shown = 32'h0000_1234 one cycle later.
- Reset mid-operation:
  - Assert Reset while Frozen = 1 and the blink phase = 1.
  - Required, immediately: Frozen = 0, Changed_Mask = 0, HEX0 = 7'h40, HEX1..HEX7 = 7'h7F.
